// File: rtl/dram_emu_pkg.sv
// Shared types and helpers for the RAS/CAS multiplexed DRAM emulation.
package dram_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    HOLD,
    COL_RF
  } state_t;

  function automatic int max_f(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous RAM; the read register only loads on re so it holds the last read word.
module dram_array #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Contents are never reset: the array survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dram_mux_emul.sv
// Clocked emulation of a 4116/4164/4416-class DRAM: pin synchroniser, strobe edge detect,
// RAS/CAS sequencing FSM and a synchronous array serving one word per CAS cycle.
module dram_mux_emul
  import dram_emu_pkg::*;
#(
  parameter int ROW_BITS    = 7,
  parameter int COL_BITS    = 7,
  parameter int DATA_WIDTH  = 1,
  parameter int SYNC_STAGES = 2,
  localparam int A_PINS     = max_f(ROW_BITS, COL_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [A_PINS-1:0]     a,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_oe,
  output logic                  rfsh,
  output state_t                dbg_state
);

  localparam int PW = 3 + A_PINS + DATA_WIDTH;
  localparam logic [PW-1:0] SYNC_RST = {3'b111, {(PW-3){1'b0}}};

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         pins_s;
  logic                  ras_s, cas_s, we_s;
  logic                  ras_p, cas_p, we_p;
  logic [A_PINS-1:0]     a_s;
  logic [DATA_WIDTH-1:0] d_s;
  logic                  ras_fall, ras_rise, cas_fall, cas_rise, we_fall;

  state_t                state;
  logic [ROW_BITS-1:0]   row_q;
  logic [COL_BITS-1:0]   col_q;
  logic                  wr_done;
  logic                  cas_seen;
  logic                  cas_pend;

  logic                  access;
  logic                  late_wr;
  logic                  ram_we, ram_re;
  logic [ROW_BITS+COL_BITS-1:0] ram_addr;

  // Strobes, address and data share one synchroniser so they stay aligned to each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {ras_n, cas_n, we_n, a, d};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pins_s = sync_q[SYNC_STAGES-1];
  assign ras_s  = pins_s[PW-1];
  assign cas_s  = pins_s[PW-2];
  assign we_s   = pins_s[PW-3];
  assign a_s    = pins_s[DATA_WIDTH +: A_PINS];
  assign d_s    = pins_s[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_p <= 1'b1;
      cas_p <= 1'b1;
      we_p  <= 1'b1;
    end else begin
      ras_p <= ras_s;
      cas_p <= cas_s;
      we_p  <= we_s;
    end
  end

  assign ras_fall = ras_p & ~ras_s;
  assign ras_rise = ~ras_p & ras_s;
  assign cas_fall = cas_p & ~cas_s;
  assign cas_rise = ~cas_p & cas_s;
  assign we_fall  = we_p & ~we_s;

  // cas_pend covers a RAS and CAS fall seen in the same sample: column access one clock later.
  assign access  = (state == ROW) && !ras_rise && (cas_fall || (cas_pend && !cas_s));
  assign late_wr = (state == COL) && !cas_rise && !ras_rise && we_fall && !wr_done;

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = {row_q, col_q};
    if (access) begin
      ram_addr = {row_q, a_s[COL_BITS-1:0]};
      ram_we   = ~we_s;
      ram_re   = we_s;
    end else if (late_wr) begin
      ram_we   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_done  <= 1'b0;
      cas_seen <= 1'b0;
      cas_pend <= 1'b0;
      q_oe     <= 1'b0;
      rfsh     <= 1'b0;
    end else begin
      rfsh     <= 1'b0;
      cas_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (ras_fall) begin
            state    <= ROW;
            row_q    <= a_s[ROW_BITS-1:0];
            // CAS already low at RAS fall is a CAS-before-RAS cycle, never a RAS-only refresh.
            cas_seen <= ~cas_s;
            cas_pend <= cas_fall;
          end
        end
        ROW: begin
          if (ras_rise) begin
            state <= IDLE;
            rfsh  <= ~cas_seen;
          end else if (access) begin
            state    <= COL;
            col_q    <= a_s[COL_BITS-1:0];
            cas_seen <= 1'b1;
            wr_done  <= ~we_s;
            q_oe     <= we_s;
          end
        end
        COL: begin
          if (cas_rise) begin
            state   <= ras_rise ? IDLE : ROW;
            wr_done <= 1'b0;
            q_oe    <= 1'b0;
          end else if (ras_rise) begin
            state <= HOLD;
          end else if (late_wr) begin
            wr_done <= 1'b1;
          end
        end
        HOLD: begin
          if (cas_rise) begin
            state   <= IDLE;
            wr_done <= 1'b0;
            q_oe    <= 1'b0;
          end else if (ras_fall) begin
            state <= COL_RF;
            row_q <= a_s[ROW_BITS-1:0];
          end
        end
        COL_RF: begin
          if (cas_rise) begin
            state    <= ras_rise ? IDLE : ROW;
            wr_done  <= 1'b0;
            q_oe     <= 1'b0;
            cas_seen <= 1'b1;
          end else if (ras_rise) begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dram_array #(
    .ADDR_BITS  (ROW_BITS + COL_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (d_s),
    .rdata (q)
  );

  assign dbg_state = state;

endmodule
